// File: rtl/int_controller.sv
// Interrupt controller: edge-latched NMI plus four level-sensitive IRQs.
// Dispatches at instruction boundaries and supports NMI nesting over IRQ service.
module int_controller #(
  parameter logic [31:0] NMI_VECTOR = 32'h0000_0040,
  parameter logic [31:0] IRQ_BASE   = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        NON_maskable_interrupt,
  input  logic [3:0]  irq_req,
  input  logic        CPU_busy,
  input  logic        instr_boundary,
  input  logic [31:0] pc_in,
  input  logic        eret,
  input  logic        mask_we,
  input  logic [4:0]  mask_wdata,
  output logic        take_int,
  output logic [31:0] vector,
  output logic        INA,
  output logic [31:0] ret_pc,
  output logic        int_active,
  output logic [2:0]  cause
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IRQ,
    S_NMI,
    S_NEST
  } state_t;

  state_t      r_state;
  logic        r_nmi_prev;
  logic        r_nmi_pend;
  logic        r_ie;
  logic        r_ie_save;
  logic [3:0]  r_mask;
  logic [31:0] r_epc;
  logic [31:0] r_nmi_epc;
  logic [1:0]  r_irq_idx;
  logic        r_take;
  logic [31:0] r_vec;

  logic        w_nmi_edge;
  logic        w_nmi_req;
  logic [3:0]  w_irq_pend;
  logic        w_irq_any;
  logic [1:0]  w_irq_idx;
  logic        w_ok;
  logic [31:0] w_irq_vec;

  assign w_nmi_edge = NON_maskable_interrupt & ~r_nmi_prev;
  assign w_nmi_req  = r_nmi_pend | w_nmi_edge;
  assign w_irq_pend = irq_req & r_mask & {4{r_ie}};
  assign w_irq_any  = |w_irq_pend;
  // eret owns its cycle; any dispatch waits for the next one
  assign w_ok       = instr_boundary & ~CPU_busy & ~eret;
  assign w_irq_vec  = IRQ_BASE + {26'd0, w_irq_idx, 4'd0};

  // Lowest set index wins among enabled maskable requests
  always_comb begin
    w_irq_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_irq_pend[i]) w_irq_idx = 2'(i);
    end
  end

  // Service FSM with saved PCs, enable save/restore and dispatch pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_nmi_prev <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_ie       <= 1'b0;
      r_ie_save  <= 1'b0;
      r_mask     <= 4'b0000;
      r_epc      <= 32'd0;
      r_nmi_epc  <= 32'd0;
      r_irq_idx  <= 2'd0;
      r_take     <= 1'b0;
      r_vec      <= 32'd0;
    end else begin
      r_nmi_prev <= NON_maskable_interrupt;
      r_take     <= 1'b0;
      r_vec      <= 32'd0;
      if (w_nmi_edge) r_nmi_pend <= 1'b1;
      if (eret) begin
        case (r_state)
          S_IRQ: begin
            r_state <= S_IDLE;
            r_ie    <= r_ie_save;
          end
          S_NMI:   r_state <= S_IDLE;
          S_NEST:  r_state <= S_IRQ;
          default: ;
        endcase
      end else if (w_ok) begin
        case (r_state)
          S_IDLE: begin
            if (w_nmi_req) begin
              r_state    <= S_NMI;
              r_nmi_pend <= 1'b0;
              r_nmi_epc  <= pc_in;
              r_take     <= 1'b1;
              r_vec      <= NMI_VECTOR;
            end else if (w_irq_any) begin
              r_state   <= S_IRQ;
              r_epc     <= pc_in;
              r_irq_idx <= w_irq_idx;
              r_ie_save <= r_ie;
              r_ie      <= 1'b0;
              r_take    <= 1'b1;
              r_vec     <= w_irq_vec;
            end
          end
          S_IRQ: begin
            if (w_nmi_req) begin
              r_state    <= S_NEST;
              r_nmi_pend <= 1'b0;
              r_nmi_epc  <= pc_in;
              r_take     <= 1'b1;
              r_vec      <= NMI_VECTOR;
            end
          end
          default: ;
        endcase
      end
      if (mask_we) {r_ie, r_mask} <= mask_wdata;
    end
  end

  assign take_int   = r_take;
  assign INA        = r_take;
  assign vector     = r_vec;
  assign int_active = (r_state != S_IDLE);
  assign ret_pc     = (r_state == S_NMI || r_state == S_NEST)
                    ? r_nmi_epc : r_epc;

  // Cause reflects the innermost active service
  always_comb begin
    cause = 3'd0;
    case (r_state)
      S_IRQ:   cause = {1'b0, r_irq_idx} + 3'd1;
      S_NMI:   cause = 3'd7;
      S_NEST:  cause = 3'd7;
      default: cause = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: expected dispatches are queued
// as stimulus is driven and popped when take_int fires.
module tb_int_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        NON_maskable_interrupt;
  logic [3:0]  irq_req;
  logic        CPU_busy;
  logic        instr_boundary;
  logic [31:0] pc_in;
  logic        eret;
  logic        mask_we;
  logic [4:0]  mask_wdata;
  logic        take_int;
  logic [31:0] vector;
  logic        INA;
  logic [31:0] ret_pc;
  logic        int_active;
  logic [2:0]  cause;

  typedef struct {
    logic [31:0] vec;
    logic [2:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  int_controller dut (
    .clock                  (clock),
    .reset                  (reset),
    .NON_maskable_interrupt (NON_maskable_interrupt),
    .irq_req                (irq_req),
    .CPU_busy               (CPU_busy),
    .instr_boundary         (instr_boundary),
    .pc_in                  (pc_in),
    .eret                   (eret),
    .mask_we                (mask_we),
    .mask_wdata             (mask_wdata),
    .take_int               (take_int),
    .vector                 (vector),
    .INA                    (INA),
    .ret_pc                 (ret_pc),
    .int_active             (int_active),
    .cause                  (cause)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_take(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (take_int === 1'b1) got = 1'b1;
      else step();
    end
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({take_int, INA, vector, ret_pc, int_active, cause} !== 70'd0) begin
      n_err++;
      $display("FAIL reset_outs: take=%b ina=%b vec=%h ret=%h act=%b cause=%0d, need all 0",
               take_int, INA, vector, ret_pc, int_active, cause);
    end
  endtask

  task automatic test_irq_basic();
    exp_t e;
    bit   got;
    mask_we = 1'b1; mask_wdata = 5'b1_1111;
    step();
    mask_we = 1'b0;
    irq_req = 4'b0100; instr_boundary = 1'b1; pc_in = 32'h20;
    sb.push_back('{32'hA0, 3'd3});
    step();
    wait_take(3, got);
    e = sb.pop_front();
    n_vec++;
    if (!got || vector !== e.vec || cause !== e.cause || INA !== 1'b1) begin
      n_err++;
      $display("FAIL irq2_disp: got=%b vec=%h cause=%0d ina=%b, need vec=%h cause=%0d ina=1",
               got, vector, cause, INA, e.vec, e.cause);
    end
    irq_req = 4'b0000; instr_boundary = 1'b0;
    step();
    n_vec++;
    if (take_int !== 1'b0 || INA !== 1'b0 || int_active !== 1'b1) begin
      n_err++;
      $display("FAIL irq2_pulse: take=%b ina=%b act=%b, need 0 0 1",
               take_int, INA, int_active);
    end
    do_eret();
    n_vec++;
    if (int_active !== 1'b0 || cause !== 3'd0 || ret_pc !== 32'h20) begin
      n_err++;
      $display("FAIL irq2_eret: act=%b cause=%0d ret=%h, need 0 0 00000020",
               int_active, cause, ret_pc);
    end
  endtask

  task automatic test_nmi_priority();
    exp_t e;
    bit   got;
    instr_boundary = 1'b0; irq_req = 4'b0001;
    NON_maskable_interrupt = 1'b1; pc_in = 32'h200;
    step();
    NON_maskable_interrupt = 1'b0; instr_boundary = 1'b1;
    sb.push_back('{32'h40, 3'd7});
    step();
    wait_take(3, got);
    e = sb.pop_front();
    n_vec++;
    if (!got || vector !== e.vec || cause !== e.cause || ret_pc !== 32'h200) begin
      n_err++;
      $display("FAIL nmi_first: got=%b vec=%h cause=%0d ret=%h, need vec=%h cause=%0d ret=200",
               got, vector, cause, ret_pc, e.vec, e.cause);
    end
    step();
    do_eret();
    n_vec++;
    if (take_int !== 1'b0 || int_active !== 1'b0) begin
      n_err++;
      $display("FAIL nmi_eret: take=%b act=%b, need 0 0", take_int, int_active);
    end
    sb.push_back('{32'h80, 3'd1});
    step();
    wait_take(3, got);
    e = sb.pop_front();
    n_vec++;
    if (!got || vector !== e.vec || cause !== e.cause) begin
      n_err++;
      $display("FAIL irq_after_nmi: got=%b vec=%h cause=%0d, need vec=%h cause=%0d",
               got, vector, cause, e.vec, e.cause);
    end
    irq_req = 4'b0000;
    step();
    do_eret();
  endtask

  task automatic test_nest();
    exp_t e;
    bit   got;
    irq_req = 4'b0001; pc_in = 32'h100; instr_boundary = 1'b1;
    sb.push_back('{32'h80, 3'd1});
    step();
    wait_take(3, got);
    e = sb.pop_front();
    n_vec++;
    if (!got || vector !== e.vec || cause !== e.cause) begin
      n_err++;
      $display("FAIL nest_irq: got=%b vec=%h cause=%0d, need vec=%h cause=%0d",
               got, vector, cause, e.vec, e.cause);
    end
    irq_req = 4'b0000; pc_in = 32'h84; instr_boundary = 1'b0;
    NON_maskable_interrupt = 1'b1;
    step();
    NON_maskable_interrupt = 1'b0; instr_boundary = 1'b1;
    sb.push_back('{32'h40, 3'd7});
    step();
    wait_take(3, got);
    e = sb.pop_front();
    n_vec++;
    if (!got || vector !== e.vec || cause !== e.cause || ret_pc !== 32'h84) begin
      n_err++;
      $display("FAIL nest_nmi: got=%b vec=%h cause=%0d ret=%h, need vec=%h cause=%0d ret=84",
               got, vector, cause, ret_pc, e.vec, e.cause);
    end
    step();
    do_eret();
    n_vec++;
    if (int_active !== 1'b1 || ret_pc !== 32'h100 || cause !== 3'd1) begin
      n_err++;
      $display("FAIL nest_back: act=%b ret=%h cause=%0d, need 1 100 1",
               int_active, ret_pc, cause);
    end
    do_eret();
    n_vec++;
    if (int_active !== 1'b0 || cause !== 3'd0) begin
      n_err++;
      $display("FAIL nest_idle: act=%b cause=%0d, need 0 0", int_active, cause);
    end
  endtask

  task automatic test_busy();
    exp_t e;
    bit   got;
    instr_boundary = 1'b1; CPU_busy = 1'b1; pc_in = 32'h400;
    NON_maskable_interrupt = 1'b1;
    step();
    NON_maskable_interrupt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (take_int !== 1'b0) begin
        n_err++;
        $display("FAIL busy_hold%0d: take=%b, need 0", i, take_int);
      end
      step();
    end
    sb.push_back('{32'h40, 3'd7});
    CPU_busy = 1'b0;
    step();
    wait_take(1, got);
    e = sb.pop_front();
    n_vec++;
    if (!got || vector !== e.vec || cause !== e.cause || ret_pc !== 32'h400) begin
      n_err++;
      $display("FAIL busy_disp: got=%b vec=%h cause=%0d ret=%h, need vec=%h cause=%0d ret=400",
               got, vector, cause, ret_pc, e.vec, e.cause);
    end
    step();
    do_eret();
  endtask

  task automatic test_drop_and_mask();
    instr_boundary = 1'b0; irq_req = 4'b0010;
    step();
    irq_req = 4'b0000; instr_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (take_int !== 1'b0 || int_active !== 1'b0) begin
        n_err++;
        $display("FAIL drop%0d: take=%b act=%b, need 0 0", i, take_int, int_active);
      end
    end
    mask_we = 1'b1; mask_wdata = 5'b0_1111;
    step();
    mask_we = 1'b0; irq_req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (take_int !== 1'b0 || int_active !== 1'b0) begin
        n_err++;
        $display("FAIL ie_off%0d: take=%b act=%b, need 0 0", i, take_int, int_active);
      end
    end
    irq_req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   got;
    instr_boundary = 1'b0; NON_maskable_interrupt = 1'b1; pc_in = 32'h300;
    step();
    NON_maskable_interrupt = 1'b0; instr_boundary = 1'b1;
    sb.push_back('{32'h40, 3'd7});
    step();
    wait_take(3, got);
    e = sb.pop_front();
    n_vec++;
    if (!got || vector !== e.vec || cause !== e.cause) begin
      n_err++;
      $display("FAIL rst_nmi1: got=%b vec=%h cause=%0d, need vec=%h cause=%0d",
               got, vector, cause, e.vec, e.cause);
    end
    NON_maskable_interrupt = 1'b1;
    step();
    NON_maskable_interrupt = 1'b0;
    step();
    reset = 1'b1;
    step();
    n_vec++;
    if ({take_int, INA, vector, ret_pc, int_active, cause} !== 70'd0) begin
      n_err++;
      $display("FAIL rst_mid: take=%b ina=%b vec=%h ret=%h act=%b cause=%0d, need all 0",
               take_int, INA, vector, ret_pc, int_active, cause);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (take_int !== 1'b0) begin
        n_err++;
        $display("FAIL rst_discard%0d: take=%b, need 0", i, take_int);
      end
    end
    instr_boundary = 1'b0; NON_maskable_interrupt = 1'b1; pc_in = 32'h500;
    step();
    NON_maskable_interrupt = 1'b0; instr_boundary = 1'b1;
    sb.push_back('{32'h40, 3'd7});
    step();
    wait_take(3, got);
    e = sb.pop_front();
    n_vec++;
    if (!got || vector !== e.vec || cause !== e.cause || ret_pc !== 32'h500) begin
      n_err++;
      $display("FAIL rst_nmi2: got=%b vec=%h cause=%0d ret=%h, need vec=%h cause=%0d ret=500",
               got, vector, cause, ret_pc, e.vec, e.cause);
    end
    step();
    do_eret();
  endtask

  initial begin
    reset = 1'b1;
    NON_maskable_interrupt = 1'b0;
    irq_req = 4'b0000;
    CPU_busy = 1'b0;
    instr_boundary = 1'b0;
    pc_in = 32'd0;
    eret = 1'b0;
    mask_we = 1'b0;
    mask_wdata = 5'd0;
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_irq_basic();
    test_nmi_priority();
    test_nest();
    test_busy();
    test_drop_and_mask();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_empty: %0d left, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 SHALL have parameter NMI_VECTOR, default 32'h0000_0040, PC loaded on NMI dispatch.
REQ-002 SHALL have parameter IRQ_BASE, default 32'h0000_0080, base of maskable vectors.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port NON_maskable_interrupt  in  1  NMI request, edge-sensitive (rising edge).
REQ-006 SHALL have port irq_req  in  4  maskable requests, level-sensitive; bit 0 highest priority.
REQ-007 SHALL have port CPU_busy  in  1  high = CPU cannot accept a dispatch this cycle.
REQ-008 SHALL have port instr_boundary  in  1  high in the cycle the CPU is in its fetch state.
REQ-009 SHALL have port pc_in  in  32  address of the next instruction to execute.
REQ-010 SHALL have port eret  in  1  one-cycle pulse: handler executed return.
REQ-011 SHALL have ports mask_we  in  1  and mask_wdata  in  5  writes {ie, mask[3:0]}.
REQ-012 SHALL have port take_int  out  1  one-cycle pulse: CPU loads PC from vector.
REQ-013 SHALL have port vector  out  32  handler address, valid while take_int high.
REQ-014 SHALL have port INA  out  1  acknowledge, high in the same cycle as take_int.
REQ-015 SHALL have port ret_pc  out  32  return address for eret.
REQ-016 SHALL have ports int_active  out  1  and cause  out  3  (0=none, 1..4=irq0..3, 7=NMI).

Function
REQ-017 SHALL latch an NMI rising edge (registered previous-value compare) into nmi_pend; nmi_pend clears only on NMI dispatch.
REQ-018 SHALL compute irq_pend = irq_req & mask & {4{ie}} combinationally each cycle; no latching.
REQ-019 SHALL implement states IDLE, IRQ_SVC, NMI_SVC, NMI_NEST (NMI over maskable service).
REQ-020 SHALL dispatch only when instr_boundary=1 and CPU_busy=0; otherwise the request waits indefinitely.
REQ-021 SHALL, in IDLE with dispatch allowed: nmi_pend -> NMI dispatch, NMI_SVC; else any irq_pend -> IRQ dispatch of lowest set index, IRQ_SVC.
REQ-022 SHALL, in IRQ_SVC: nmi_pend with dispatch allowed -> NMI dispatch, NMI_NEST; maskable requests not dispatched.
REQ-023 SHALL, in NMI_SVC and NMI_NEST, dispatch nothing; a new NMI edge is latched and served after eret.
REQ-024 SHALL, on dispatch, assert take_int and INA for exactly one cycle and drive vector = NMI_VECTOR or IRQ_BASE + 16*index (32-bit, no overflow at defaults).
REQ-025 SHALL, on dispatch, capture pc_in into epc (IRQ) or nmi_epc (NMI) at that edge.
REQ-026 SHALL drive ret_pc = nmi_epc in NMI_SVC/NMI_NEST, epc otherwise.
REQ-027 SHALL on eret: IRQ_SVC -> IDLE; NMI_SVC -> IDLE; NMI_NEST -> IRQ_SVC (epc preserved); IDLE ignores eret.
REQ-028 SHALL clear ie on IRQ dispatch and restore ie to its pre-dispatch value on the eret leaving IRQ_SVC; mask_we in the same cycle overrides.
REQ-029 SHALL treat eret and a dispatch-eligible request in the same cycle as eret first; dispatch no earlier than next cycle.
REQ-030 SHALL drive int_active = (state != IDLE); cause = source of the innermost active service, 0 in IDLE.
REQ-031 SHALL, with NMI and IRQ pending simultaneously, dispatch NMI first.
REQ-032 SHALL not dispatch an IRQ whose level dropped before the dispatch cycle.

Reset
REQ-033 SHALL on reset: state=IDLE, nmi_pend=0, NMI edge register=0, ie=0, mask=4'b0000, epc=nmi_epc=0.
REQ-034 SHALL on reset drive take_int=0, INA=0, vector=0, ret_pc=0, int_active=0, cause=0.
REQ-035 SHALL on reset mid-service abandon the service, discarding saved PCs and pending NMI.

Verification
REQ-036 SHALL test: mask_wdata=5'b1_1111, irq_req=4'b0100, boundary=1, pc_in=0x20 -> take_int/INA 1 cycle, vector=0xA0, cause=3; eret -> IDLE, ret_pc=0x20.
REQ-037 SHALL test: NMI pulse with irq_req=4'b0001 same cycle -> vector=0x40, cause=7; after eret, IRQ dispatch vector=0x80.
REQ-038 SHALL test: IRQ service active (epc=0x100), NMI at pc_in=0x84 -> NMI_NEST, ret_pc=0x84; eret -> IRQ_SVC, ret_pc=0x100, cause=1.
REQ-039 SHALL test: CPU_busy=1 for 5 cycles with NMI pending -> no take_int; dispatch on first cycle busy=0 and boundary=1.
REQ-040 SHALL test: irq_req pulse dropped before boundary -> no dispatch; ie=0 -> no dispatch.
REQ-041 SHALL test: reset asserted in NMI_SVC -> all outputs 0 next cycle, later NMI edge dispatched normally.
